// File: rtl/reg_arb_pkg.sv
// Shared constants and request-operation encoding for the register access arbiter.
package reg_arb_pkg;

    localparam int DEF_NUM_REQ  = 4;
    localparam int DEF_NUM_REGS = 4;
    localparam int DEF_DATA_W   = 8;

    // Encoding matches the req_write bit: 1 = write, 0 = read.
    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } req_op_e;

endpackage

// File: rtl/register_module.sv
// Single storage register with synchronous reset and write enable.
module register_module
    import reg_arb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write_enable,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] q
);

    // Load wdata when enabled; reset clears the contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (write_enable) begin
            q <= wdata;
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr, wrapping.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant
);

    localparam int PW = $clog2(N);

    logic [31:0]   sum;
    logic [PW-1:0] idx;
    logic          found;

    // Scan requesters starting at ptr; the first valid one wins.
    always_comb begin
        grant = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            sum = 32'(ptr) + k;
            if (sum >= N) begin
                sum = sum - N;
            end
            idx = PW'(sum);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_access_arbiter.sv
// Round-robin shared access to a bank of registers over a valid/ready handshake.
module reg_access_arbiter
    import reg_arb_pkg::*;
#(
    parameter int NUM_REQ  = DEF_NUM_REQ,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int DATA_W   = DEF_DATA_W
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_REQ-1:0]                   req_valid,
    input  logic [NUM_REQ-1:0]                   req_write,
    input  logic [NUM_REQ*$clog2(NUM_REGS)-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]            req_wdata,
    output logic [NUM_REQ-1:0]                   req_ready,
    output logic [NUM_REQ-1:0]                   rsp_valid,
    output logic [DATA_W-1:0]                    rsp_rdata,
    output logic [NUM_REGS*DATA_W-1:0]           reg_q
);

    localparam int AW = $clog2(NUM_REGS);
    localparam int PW = $clog2(NUM_REQ);

    logic [PW-1:0]       ptr;
    logic [NUM_REQ-1:0]  arb_grant;
    logic [NUM_REQ-1:0]  grant;
    logic [PW-1:0]       gidx;
    logic                hs;
    req_op_e             sel_op;
    logic [AW-1:0]       sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic [DATA_W-1:0]   rd_data;
    logic [NUM_REGS-1:0] we;

    rr_arbiter #(
        .N(NUM_REQ)
    ) u_arb (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (arb_grant)
    );

    // Reset suppresses any grant so nothing handshakes during rst.
    always_comb begin
        grant = rst ? '0 : arb_grant;
    end

    assign req_ready = grant;
    assign hs        = |grant;

    // Route the granted requester's command to the shared write/read path.
    always_comb begin
        gidx      = '0;
        sel_op    = OP_READ;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                gidx      = PW'(i);
                sel_op    = req_op_e'(req_write[i]);
                sel_addr  = req_addr[i*AW +: AW];
                sel_wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Read mux: register contents before the handshake edge.
    always_comb begin
        rd_data = '0;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            if (sel_addr == AW'(r)) begin
                rd_data = reg_q[r*DATA_W +: DATA_W];
            end
        end
    end

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_regs
        assign we[r] = hs && (sel_op == OP_WRITE) && (sel_addr == AW'(r));

        register_module #(
            .DATA_W(DATA_W)
        ) u_reg (
            .clk          (clk),
            .rst          (rst),
            .write_enable (we[r]),
            .wdata        (sel_wdata),
            .q            (reg_q[r*DATA_W +: DATA_W])
        );
    end

    // Priority pointer moves just past the requester that completed a handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (hs) begin
            if (gidx == PW'(NUM_REQ - 1)) begin
                ptr <= '0;
            end else begin
                ptr <= gidx + PW'(1);
            end
        end
    end

    // One-cycle read response; data holds when no read completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= '0;
            rsp_rdata <= '0;
        end else if (hs && (sel_op == OP_READ)) begin
            rsp_valid <= grant;
            rsp_rdata <= rd_data;
        end else begin
            rsp_valid <= '0;
        end
    end

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Self-checking bench for reg_access_arbiter against a behavioural reference model.
module tb_reg_access_arbiter;

    localparam int NR = 4;
    localparam int NG = 4;
    localparam int DW = 8;
    localparam int AW = 2;

    logic             clk;
    logic             rst;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_write;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_wdata;
    logic [NR-1:0]    req_ready;
    logic [NR-1:0]    rsp_valid;
    logic [DW-1:0]    rsp_rdata;
    logic [NG*DW-1:0] reg_q;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int            m_ptr;
    logic [DW-1:0] m_regs [NG];
    logic [NR-1:0] m_rsp_valid;
    logic [DW-1:0] m_rsp_rdata;

    reg_access_arbiter #(
        .NUM_REQ  (NR),
        .NUM_REGS (NG),
        .DATA_W   (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .reg_q     (reg_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [NR-1:0] model_grant();
        if (rst) return '0;
        for (int k = 0; k < NR; k++) begin
            int idx;
            idx = (m_ptr + k) % NR;
            if (req_valid[idx]) return NR'(1 << idx);
        end
        return '0;
    endfunction

    function automatic logic [NG*DW-1:0] model_regs();
        logic [NG*DW-1:0] v;
        v = '0;
        for (int r = 0; r < NG; r++) v[r*DW +: DW] = m_regs[r];
        return v;
    endfunction

    // Advance one clock and apply the architectural effect of the edge to the model.
    task automatic step();
        logic [NR-1:0] g;
        int            a;
        g = model_grant();
        @(posedge clk);
        if (rst) begin
            m_ptr       = 0;
            m_rsp_valid = '0;
            m_rsp_rdata = '0;
            for (int r = 0; r < NG; r++) m_regs[r] = '0;
        end else begin
            m_rsp_valid = '0;
            for (int i = 0; i < NR; i++) begin
                if (g[i]) begin
                    a = int'(req_addr[i*AW +: AW]);
                    if (req_write[i]) begin
                        m_regs[a] = req_wdata[i*DW +: DW];
                    end else begin
                        m_rsp_valid = g;
                        m_rsp_rdata = m_regs[a];
                    end
                    m_ptr = (i + 1) % NR;
                end
            end
        end
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic w,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]          = v;
        req_write[i]          = w;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic clear_all();
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_all();
        step();
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b0, AW'(i), '0);
        #1;
        n_checks++;
        if (req_ready !== 4'b0000) begin
            n_fail++; $display("FAIL reset_ready: got %b expected 0000", req_ready);
        end
        step();
        n_checks++;
        if (rsp_valid !== 4'b0000) begin
            n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0000", rsp_valid);
        end
        n_checks++;
        if (reg_q !== 32'h0) begin
            n_fail++; $display("FAIL reset_reg_q: got %h expected 00000000", reg_q);
        end
        n_checks++;
        if (rsp_rdata !== 8'h00) begin
            n_fail++; $display("FAIL reset_rsp_rdata: got %h expected 00", rsp_rdata);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (req_ready !== 4'b0001) begin
            n_fail++; $display("FAIL reset_first_grant: got %b expected 0001", req_ready);
        end
        step();
        clear_all();
    endtask

    task automatic test_single_write_read();
        clear_all();
        set_req(0, 1'b1, 1'b1, 2'd2, 8'hA5);
        #1;
        n_checks++;
        if (req_ready !== 4'b0001) begin
            n_fail++; $display("FAIL single_wr_ready: got %b expected 0001", req_ready);
        end
        step();
        n_checks++;
        if (reg_q[2*DW +: DW] !== 8'hA5 || rsp_valid !== 4'b0000) begin
            n_fail++; $display("FAIL single_wr_commit: got reg2=%h rsp_valid=%b expected A5 0000", reg_q[2*DW +: DW], rsp_valid);
        end
        set_req(0, 1'b1, 1'b0, 2'd2, 8'h00);
        #1;
        n_checks++;
        if (req_ready !== 4'b0001) begin
            n_fail++; $display("FAIL single_rd_ready: got %b expected 0001", req_ready);
        end
        step();
        n_checks++;
        if (rsp_valid !== 4'b0001 || rsp_rdata !== 8'hA5) begin
            n_fail++; $display("FAIL single_rd_rsp: got %b/%h expected 0001/A5", rsp_valid, rsp_rdata);
        end
        clear_all();
        step();
        n_checks++;
        if (rsp_valid !== 4'b0000 || rsp_rdata !== 8'hA5) begin
            n_fail++; $display("FAIL single_rd_hold: got %b/%h expected 0000/A5", rsp_valid, rsp_rdata);
        end
    endtask

    task automatic test_round_robin();
        logic [NR-1:0] exp_g;
        rst = 1'b1;
        clear_all();
        step();
        rst = 1'b0;
        // Preload reg i with 0x11*(i+1), one requester at a time, leaving ptr at 0.
        for (int i = 0; i < NR; i++) begin
            clear_all();
            set_req(i, 1'b1, 1'b1, AW'(i), DW'(8'h11 * (i + 1)));
            step();
        end
        clear_all();
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b0, AW'((i + 1) % NR), '0);
        for (int k = 0; k < 5; k++) begin
            exp_g = NR'(1 << (k % NR));
            #1;
            n_checks++;
            if (req_ready !== exp_g) begin
                n_fail++; $display("FAIL rr_grant[%0d]: got %b expected %b", k, req_ready, exp_g);
            end
            step();
            n_checks++;
            if (rsp_valid !== exp_g || rsp_rdata !== m_rsp_rdata) begin
                n_fail++; $display("FAIL rr_rsp[%0d]: got %b/%h expected %b/%h", k, rsp_valid, rsp_rdata, exp_g, m_rsp_rdata);
            end
        end
        clear_all();
    endtask

    task automatic test_ordering();
        rst = 1'b1;
        clear_all();
        step();
        rst = 1'b0;
        set_req(2, 1'b1, 1'b0, 2'd1, '0);
        #1;
        n_checks++;
        if (req_ready !== 4'b0100) begin
            n_fail++; $display("FAIL order_pre_ready: got %b expected 0100", req_ready);
        end
        step();
        clear_all();
        set_req(1, 1'b1, 1'b1, 2'd1, 8'h3C);
        #1;
        n_checks++;
        if (rsp_valid !== 4'b0100 || rsp_rdata !== 8'h00) begin
            n_fail++; $display("FAIL order_old_value: got %b/%h expected 0100/00", rsp_valid, rsp_rdata);
        end
        step();
        clear_all();
        set_req(2, 1'b1, 1'b0, 2'd1, '0);
        step();
        n_checks++;
        if (rsp_valid !== 4'b0100 || rsp_rdata !== 8'h3C) begin
            n_fail++; $display("FAIL order_new_value: got %b/%h expected 0100/3C", rsp_valid, rsp_rdata);
        end
        clear_all();
    endtask

    task automatic test_starvation_wrap();
        clear_all();
        set_req(2, 1'b1, 1'b0, 2'd0, '0);
        step();
        clear_all();
        set_req(3, 1'b1, 1'b0, 2'd1, '0);
        set_req(0, 1'b1, 1'b0, 2'd2, '0);
        #1;
        n_checks++;
        if (req_ready !== 4'b1000) begin
            n_fail++; $display("FAIL wrap_first: got %b expected 1000", req_ready);
        end
        step();
        set_req(3, 1'b0, 1'b0, 2'd0, '0);
        #1;
        n_checks++;
        if (req_ready !== 4'b0001) begin
            n_fail++; $display("FAIL wrap_second: got %b expected 0001", req_ready);
        end
        step();
        clear_all();
        set_req(2, 1'b1, 1'b0, 2'd3, '0);
        for (int k = 0; k < 4; k++) begin
            #1;
            n_checks++;
            if (req_ready !== 4'b0100) begin
                n_fail++; $display("FAIL solo_grant[%0d]: got %b expected 0100", k, req_ready);
            end
            step();
            n_checks++;
            if (rsp_valid !== 4'b0100 || rsp_rdata !== m_rsp_rdata) begin
                n_fail++; $display("FAIL solo_rsp[%0d]: got %b/%h expected 0100/%h", k, rsp_valid, rsp_rdata, m_rsp_rdata);
            end
        end
        clear_all();
    endtask

    task automatic test_reset_midop();
        clear_all();
        set_req(1, 1'b1, 1'b1, 2'd3, 8'h77);
        step();
        clear_all();
        set_req(0, 1'b1, 1'b0, 2'd3, '0);
        step();
        rst = 1'b1;
        set_req(1, 1'b1, 1'b1, 2'd2, 8'h99);
        #1;
        n_checks++;
        if (req_ready !== 4'b0000 || rsp_valid !== 4'b0001 || rsp_rdata !== 8'h77) begin
            n_fail++; $display("FAIL midop_before: got %b %b %h expected 0000 0001 77", req_ready, rsp_valid, rsp_rdata);
        end
        step();
        n_checks++;
        if (rsp_valid !== 4'b0000 || reg_q !== 32'h0) begin
            n_fail++; $display("FAIL midop_after: got %b %h expected 0000 00000000", rsp_valid, reg_q);
        end
        rst = 1'b0;
        clear_all();
        step();
    endtask

    task automatic test_random();
        logic          hv [NR];
        logic          hw [NR];
        logic [AW-1:0] ha [NR];
        logic [DW-1:0] hd [NR];
        int            waits [NR];
        logic [NR-1:0] eg;
        for (int i = 0; i < NR; i++) begin
            hv[i] = 1'b0; hw[i] = 1'b0; ha[i] = '0; hd[i] = '0; waits[i] = 0;
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < NR; i++) set_req(i, hv[i], hw[i], ha[i], hd[i]);
            rst = ($urandom_range(0, 39) == 0);
            #1;
            eg = model_grant();
            n_checks++;
            if (req_ready !== eg) begin
                n_fail++; $display("FAIL rand_grant[%0d]: got %b expected %b", cyc, req_ready, eg);
            end
            for (int i = 0; i < NR; i++) begin
                if (rst || !hv[i] || eg[i]) begin
                    waits[i] = 0;
                end else begin
                    waits[i]++;
                    n_checks++;
                    if (waits[i] >= NR) begin
                        n_fail++; $display("FAIL rand_starve[%0d]: req%0d waited %0d expected < %0d", cyc, i, waits[i], NR);
                    end
                end
            end
            step();
            n_checks++;
            if (rsp_valid !== m_rsp_valid || rsp_rdata !== m_rsp_rdata || reg_q !== model_regs()) begin
                n_fail++; $display("FAIL rand_state[%0d]: got %b/%h/%h expected %b/%h/%h", cyc, rsp_valid, rsp_rdata, reg_q, m_rsp_valid, m_rsp_rdata, model_regs());
            end
            for (int i = 0; i < NR; i++) begin
                if (eg[i] || !hv[i]) begin
                    hv[i] = ($urandom_range(0, 2) != 0);
                    hw[i] = $urandom_range(0, 1) == 1;
                    ha[i] = AW'($urandom_range(0, NG - 1));
                    hd[i] = DW'($urandom);
                end
            end
        end
        rst = 1'b0;
        clear_all();
        step();
    endtask

    initial begin
        rst = 1'b1;
        clear_all();
        m_ptr       = 0;
        m_rsp_valid = '0;
        m_rsp_rdata = '0;
        for (int r = 0; r < NG; r++) m_regs[r] = '0;
        test_reset();
        test_single_write_read();
        test_round_robin();
        test_ordering();
        test_starvation_wrap();
        test_reset_midop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_access_arbiter.md
# reg_access_arbiter

Shares one bank of 8-bit storage registers among several requesters over a valid/ready handshake. Each cycle it grants at most one request, round-robin, and drives that register's write enable or captures its read data. It sits between datapath clients (ALU writeback, load unit, debug port) and the register bank, and owns the bank instances.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters (2..8)
- NUM_REGS, 4: number of registers in the bank (power of two, ≥2)
- DATA_W, 8: register width
- AW, $clog2(NUM_REGS): address width (derived, not overridden)

Ports:
- clk  in  1  rising-edge clock, single clock domain
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  request present, per requester
- req_write  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ×AW  target register
- req_wdata  in  NUM_REQ×DATA_W  write data
- req_ready  out  NUM_REQ  one-hot grant, combinational
- rsp_valid  out  NUM_REQ  one-hot read-response strobe, registered
- rsp_rdata  out  DATA_W  read data, shared, valid when any rsp_valid bit is set
- reg_q  out  NUM_REGS×DATA_W  current contents of every register, for observation

## Operation
- Arbitration is combinational from req_valid and a registered priority pointer ptr (0..NUM_REQ-1).
  - Grant goes to the first valid requester at or after ptr, wrapping.
  - req_ready = grant; at most one bit is set.
  - No grant when no requests are valid, and none while rst=1.
- Handshake completes when req_valid[i] and req_ready[i] are both 1.
  - Requesters hold valid, write, addr and wdata stable until the handshake completes.
  - Dropping valid early is a protocol violation; behaviour is undefined.
- On a handshake by requester i, ptr <= (i+1) mod NUM_REQ. Otherwise ptr holds.
- Write handshake: the register at req_addr[i] loads req_wdata[i] at the same clock edge. No response is issued.
- Read handshake: at that edge the block captures the register value as it was before the edge, plus one-hot i.
  - rsp_valid[i] = 1 and rsp_rdata = captured value for exactly the next cycle.
  - When no read handshake occurs, rsp_valid = 0 and rsp_rdata holds its last value.
- Ordering: a write granted in cycle N is visible to a read granted in cycle N+1 or later.
- State machine: none beyond ptr and the response register. The block accepts one request per cycle with no bubbles.
- Reset values: ptr = 0, every register = 0, reg_q all 0, rsp_valid = 0, rsp_rdata = 0, req_ready = 0.

## Timing
- Grant: 0 cycles, combinational from req_valid and ptr.
- Write commit: at the handshake edge. reg_q shows the new value from the next cycle.
- Read latency: 1 cycle. rsp_valid pulses the cycle after the handshake.
- Throughput: 1 handshake per cycle. Back-to-back reads from different requesters give back-to-back rsp_valid pulses.
- Starvation bound: a held request is granted within NUM_REQ cycles.
- Simultaneous events:
  - Multiple valid requests: only one is granted; the others wait, ready=0.
  - A requester re-asserting immediately after its own grant loses to any other valid requester.
- Reset mid-operation: rst overrides everything at the edge.
  - A pending response is dropped; rsp_valid = 0 the cycle after rst.
  - A write granted in the same cycle as rst does not commit; registers = 0.
  - ptr = 0.

## Structure
- Shared package reg_arb_pkg holds the default NUM_REQ/NUM_REGS/DATA_W constants and the typedef req_op_e (OP_READ, OP_WRITE) matching req_write encoding.
- Sub-module rr_arbiter (parameter N): req vector and pointer in, one-hot grant out, combinational. It is reused by the future memory-port arbiter.
- Storage is NUM_REGS instances of register_module: 8-bit, synchronous reset, write_enable. Write enable = write handshake AND address decode.

## Test plan
- Reset: assert rst with req_valid=4'b1111 -> req_ready=0, rsp_valid=0, reg_q all 0x00. First grant after rst is requester 0.
- Single write/read: req0 writes 0xA5 to reg 2; req0 reads reg 2 next cycle -> rsp_valid=4'b0001 and rsp_rdata=0xA5 one cycle after the read grant.
- Round-robin: req_valid=4'b1111 held with reads -> grants 0,1,2,3,0 on consecutive cycles. rsp_valid follows one cycle later in the same order.
- Same-cycle ordering: req1 writes 0x3C to reg1 in cycle N; req2 reads reg1 in cycle N+1 -> rsp_rdata=0x3C. A read granted in cycle N-1 returns the old value 0x00.
- Starvation/wrap: ptr=3, only req3 and req0 valid -> req3 granted, then req0. With only req2 held, it is granted every cycle.
- Reset mid-op: read handshake in cycle N with rst=1 at the same edge -> rsp_valid=0 in N+1. A write in that cycle does not land; reg_q stays 0.
